mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Synthesizable single-port word memory that answers the multicycle RV32I datapath's memory interface (mem_read / mem_write / mem_byte_enable / mem_resp).
- Accepts one request at a time, waits a parameterized latency, then commits the write or returns read data with a one-cycle mem_resp pulse.
- Serves as the memory-side endpoint in simulation and FPGA bring-up; replaces the behavioural testbench memory.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_read  input  1  read request, level, held by initiator until mem_resp
- mem_write  input  1  write request, level, held by initiator until mem_resp
- mem_byte_enable  input  4  write byte lanes; bit i enables mem_wdata[8i+7:8i]
- mem_address  input  32  byte address
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data, valid only while mem_resp=1
- mem_resp  output  1  single-cycle completion pulse
- protocol_err  output  1  sticky flag: read and write asserted in the same cycle

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, mem_resp=0, mem_rdata=0, protocol_err=0, wait counter=0. Memory array is not cleared.
- Addressing: word index = mem_address[ADDR_WIDTH+1:2]. Bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo depth.
- States:
  - IDLE: if mem_read or mem_write is high, latch address, wdata, byte_enable and op. Counter = LATENCY-1. Go to WAIT if LATENCY>1, else RESP.
  - WAIT: decrement counter each cycle; at 0 go to RESP. Inputs are ignored, and dropping the request mid-flight does not abort it.
  - RESP: mem_resp=1 for exactly this cycle.
    - Read: mem_rdata = mem[latched index].
    - Write: mem[latched index] updated per latched byte enables; mem_rdata holds its previous value.
    - Next state IDLE.
- Latency: acceptance in cycle N gives mem_resp in cycle N+LATENCY.
- Back-to-back: a request is re-sampled in the IDLE cycle after RESP. The initiator must drop the request the cycle after mem_resp; a level still high in that IDLE cycle is a new request.
- Simultaneous read and write in IDLE: write wins; protocol_err set and held until rst.
- mem_byte_enable=0 on a write: a normal transaction with resp, and memory is unchanged.
- mem_rdata holds its last value when mem_resp=0.
- Reset mid-operation (WAIT or RESP): return to IDLE with mem_resp=0 the next cycle. A pending write is not committed unless its RESP cycle already completed.
- Write-commit happens only in RESP, so a read after write to the same address returns the new data.

Optional Feature:
- Macro MEM_RESP_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) seeded to 8'hA5 on rst advances once per accepted request.
  - lfsr[1:0] sampled at acceptance adds 0..3 extra WAIT cycles, so latency = LATENCY + lfsr[1:0].
  - Stresses the initiator's mem_resp wait loops.
- Undefined: fixed latency exactly LATENCY; no LFSR logic present.

Test Plan:
- Reset then write 0xDEADBEEF to 0x00000010 with be=4'b1111, then read 0x00000010 → write resp at acceptance+3; read resp at +3 with mem_rdata=0xDEADBEEF.
- Preload 0x11223344 at 0x20, write 0xAABBCCDD with be=4'b0001, then be=4'b0011 at 0x22 (ignored low bits) → final read returns 0x1122CCDD; mem_resp pulses exactly one cycle each.
- Write 0x5 to 0x0, read 0x1000 (ADDR_WIDTH=10, wraps to index 0) → mem_rdata=0x00000005.
- Assert mem_read and mem_write together with wdata 0x77 at 0x8 → treated as write; protocol_err=1 and stays 1; later read of 0x8 returns 0x77.
- Start write of 0xFFFFFFFF to 0x4 (previously 0x0), assert rst for one cycle during WAIT → no mem_resp; after reset, read of 0x4 returns 0x0.
- With MEM_RESP_STALL_EN, four reads → latencies equal 3 + successive LFSR[1:0] values from seed 0xA5; data correct on each.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder -- single-port 32-bit word memory serving the multicycle RV32I
// datapath memory interface. One request is accepted at a time. Its write is
// committed, or its read data returned, together with a one-cycle mem_resp
// pulse LATENCY cycles after acceptance.
//
// Optional feature: define MEM_RESP_STALL_EN to add 0..3 pseudo-random extra
// wait cycles per request. The extra count comes from an 8-bit Fibonacci LFSR
// (taps 8,6,5,4) that is seeded to 8'hA5 on rst.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   mem_read        read request (level, held until mem_resp)
//   mem_write       write request (level, held until mem_resp)
//   mem_byte_enable write byte lanes; bit i enables mem_wdata[8i+7:8i]
//   mem_address     byte address; word index = mem_address[ADDR_WIDTH+1:2]
//   mem_wdata       write data
//   mem_rdata       read data, valid while mem_resp=1, held otherwise
//   mem_resp        single-cycle completion pulse
//   protocol_err    sticky: read and write seen together on acceptance
module mem_responder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        protocol_err
);

   localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [4:0]  LAT_M1 = 5'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   logic [31:0]           mem [DEPTH];

   state_t                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic [3:0]            be_q;
   logic                  wr_q;
   logic [31:0]           rdata_q;
   logic                  perr_q;

   logic                  req;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] idx_in;
   logic [4:0]            load_cnt;
   logic [4:0]            extra;
   logic                  rd_next;
   logic [ADDR_WIDTH-1:0] idx_next;

   // Byte offset and bits above the index are don't-care; addresses wrap.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{mem_address[1:0], mem_address[31:ADDR_WIDTH+2]};

   assign idx_in   = mem_address[ADDR_WIDTH+1:2];
   assign req      = mem_read | mem_write;
   assign accept   = (state_q == S_IDLE) && req;
   assign load_cnt = LAT_M1 + extra;

`ifdef MEM_RESP_STALL_EN
   logic [7:0] lfsr_q;

   // Extra delay uses the value present at acceptance, then the LFSR steps.
   assign extra = {3'b000, lfsr_q[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 8'hA5;
      end else if (accept) begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end
`else
   assign extra = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d   = load_cnt;
               state_d = (load_cnt == '0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Read data is fetched on the edge that enters RESP. When LATENCY is 1 that
   // edge is also the acceptance edge, so the live inputs supply op and index.
   assign rd_next  = (state_q == S_IDLE) ? !mem_write : !wr_q;
   assign idx_next = (state_q == S_IDLE) ? idx_in : idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_d == S_RESP && rd_next) begin
            rdata_q <= mem[idx_next];
         end
         if (accept && mem_read && mem_write) begin
            perr_q <= 1'b1;
         end
      end
   end

   // Request capture; a simultaneous read+write is handled as a write.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= idx_in;
         wdata_q <= mem_wdata;
         be_q    <= mem_byte_enable;
         wr_q    <= mem_write;
      end
   end

   // Commit happens only in RESP, so a reset during WAIT drops the write.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_RESP && wr_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign mem_resp     = (state_q == S_RESP);
   assign mem_rdata    = rdata_q;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   localparam int unsigned AW    = 10;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 2 ** AW;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [int];
   logic [31:0] last_rdata;
   logic [7:0]  lfsr_m;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_WIDTH (AW),
      .LATENCY    (LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .protocol_err    (protocol_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] addr);
      return int'((addr / 4) % DEPTH);
   endfunction

   // Extra stall cycles the model expects for the next accepted request.
   function automatic int take_extra();
      int e = 0;
`ifdef MEM_RESP_STALL_EN
      e = int'(lfsr_m % 4);
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
      return e;
   endfunction

   task automatic txn(input string tag, input logic rd, input logic wr,
                      input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd);
      int n = 0;
      bit got = 0;
      int exp_lat;
      logic [31:0] exp_rd;
      logic [31:0] old;
      int k;
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_byte_enable = be;
      mem_address = addr; mem_wdata = wd;
      exp_lat = int'(LAT) + take_extra();
      while (!got && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (mem_resp === 1'b1) got = 1;
      end
      mem_read = 0; mem_write = 0;
      check({tag, " resp_seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(n), 32'(exp_lat));
      k = widx(addr);
      if (wr) begin
         old = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
         ref_mem[k] = old;
         exp_rd = last_rdata;
      end else begin
         exp_rd = ref_mem[k];
      end
      check({tag, " rdata"}, mem_rdata, exp_rd);
      last_rdata = exp_rd;
      @(posedge clk);
      @(negedge clk);
      check({tag, " pulse_one_cycle"}, 32'(mem_resp), 32'd0);
   endtask

   initial begin
      int seen;
      rst = 1; mem_read = 0; mem_write = 0; mem_byte_enable = '0;
      mem_address = '0; mem_wdata = '0;
      last_rdata = '0; lfsr_m = 8'hA5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset resp", 32'(mem_resp), 32'd0);
      check("reset rdata", mem_rdata, 32'h0);
      check("reset perr", 32'(protocol_err), 32'd0);
      rst = 0;

      txn("wr10", 0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
      txn("rd10", 1, 0, 4'h0, 32'h10, 32'h0);

      txn("pre20", 0, 1, 4'hF, 32'h20, 32'h11223344);
      txn("be1",   0, 1, 4'h1, 32'h20, 32'hAABBCCDD);
      txn("be3",   0, 1, 4'h3, 32'h22, 32'hAABBCCDD);
      txn("rd20",  1, 0, 4'h0, 32'h20, 32'h0);
      check("rd20 literal", mem_rdata, 32'h1122CCDD);

      txn("wr0", 0, 1, 4'hF, 32'h0, 32'h5);
      txn("wrap1000", 1, 0, 4'h0, 32'h1000, 32'h0);
      check("wrap literal", mem_rdata, 32'h5);

      txn("be0 pre", 0, 1, 4'hF, 32'hC, 32'hCAFEF00D);
      txn("be0 wr", 0, 1, 4'h0, 32'hC, 32'h12345678);
      txn("be0 rd", 1, 0, 4'h0, 32'hC, 32'h0);

      txn("both", 1, 1, 4'hF, 32'h8, 32'h77);
      check("perr set", 32'(protocol_err), 32'd1);
      txn("rd8", 1, 0, 4'h0, 32'h8, 32'h0);
      check("rd8 literal", mem_rdata, 32'h77);
      check("perr sticky", 32'(protocol_err), 32'd1);

      // Reset during WAIT: write must be dropped and no response given.
      txn("pre4", 0, 1, 4'hF, 32'h4, 32'h0);
      @(negedge clk);
      mem_write = 1; mem_byte_enable = 4'hF; mem_address = 32'h4; mem_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      rst = 1; mem_write = 0;
      @(posedge clk);
      @(negedge clk);
      check("rst mid resp", 32'(mem_resp), 32'd0);
      rst = 0; lfsr_m = 8'hA5; last_rdata = '0;
      check("rst mid rdata", mem_rdata, 32'h0);
      check("rst mid perr", 32'(protocol_err), 32'd0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_resp === 1'b1) seen++;
      end
      check("rst no late resp", 32'(seen), 32'd0);
      txn("rd4", 1, 0, 4'h0, 32'h4, 32'h0);

      // Randomized traffic over 16 words with random ignored address bits.
      for (int t = 0; t < 40; t++) begin
         int w;
         logic [31:0] a;
         bit known;
         w = int'($urandom_range(15, 0));
         a = ($urandom & ~32'h0000_0FFC) | (32'(w) << 2);
         known = ref_mem.exists(widx(a));
         if (known && $urandom_range(1, 0) == 1)
            txn("rand rd", 1, 0, 4'h0, a, 32'h0);
         else
            txn("rand wr", 0, 1, known ? 4'($urandom) : 4'hF, a, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
